aes_noc_cipher: RTL



---
 rtl/aes_noc_cipher.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/aes_noc_cipher.sv
// aes_noc_cipher
// Iterative AES block encryption engine on the NOC16 64-bit command/data channel.
// One AES round is computed per clock; AES-128/192/256 is chosen by NR, and
// ECB or CBC is selected at run time.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   rx_lo[63:0]    receive payload
//   rx_cmd[7:0]    0 key beat, 1 IV beat, 2 plaintext beat, 3 mode, 4 resync
//   rx_valid       receive beat valid
//   rx_rdy         engine accepts a receive beat (registered, high only in IDLE)
//   tx_lo[63:0]    ciphertext half, low half first
//   tx_cmd[7:0]    CMD_OUT while a beat is presented
//   tx_valid       ciphertext beat valid
//   tx_rdy         downstream accepts the beat
//   busy           high in any state other than IDLE
//   block_count    ciphertext blocks fully delivered, wraps at 2^16
//
// state  | meaning
// IDLE   | accepting key, IV, mode, resync and plaintext beats
// ROUND  | one AES round per clock, r is the round being applied
// OUT_LO | presenting ciphertext bits [63:0]
// OUT_HI | presenting ciphertext bits [127:64]
module aes_noc_cipher #(
  parameter int         NR      = 10,
  parameter logic [7:0] CMD_OUT = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] rx_lo,
  input  logic [7:0]  rx_cmd,
  input  logic        rx_valid,
  output logic        rx_rdy,
  output logic [63:0] tx_lo,
  output logic [7:0]  tx_cmd,
  output logic        tx_valid,
  input  logic        tx_rdy,
  output logic        busy,
  output logic [15:0] block_count
);

  localparam int KW = $clog2(2 * (NR + 1));
  localparam int RW = $clog2(NR + 1);

  typedef enum logic [1:0] {IDLE, ROUND, OUT_LO, OUT_HI} state_t;

  state_t                state;
  logic [128*(NR+1)-1:0] rk;
  logic [127:0]          iv;
  logic [127:0]          st;
  logic [127:0]          sr;
  logic [127:0]          round_out;
  logic [63:0]           buffer;
  logic [KW-1:0]         key_idx;
  logic                  iv_idx;
  logic                  pt_idx;
  logic                  cbc;
  logic [RW-1:0]         r;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box: multiplicative inverse as a^254 (maps 0 to 0), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int b = 0; b < 16; b++) o[8*b +: 8] = sbox(s[8*b +: 8]);
    return o;
  endfunction

  // Byte b = row (b % 4), column (b / 4); row n rotates left by n columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int col = 0; col < 4; col++)
      for (int row = 0; row < 4; row++)
        o[8*(4*col+row) +: 8] = s[8*(4*((col+row)%4)+row) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int col = 0; col < 4; col++) begin
      a0 = s[32*col +: 8];
      a1 = s[32*col+8 +: 8];
      a2 = s[32*col+16 +: 8];
      a3 = s[32*col+24 +: 8];
      o[32*col +: 32] = {xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3),
                         a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                         a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                         xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3};
    end
    return o;
  endfunction

  assign sr        = shift_rows(sub_bytes(st));
  assign round_out = ((r == RW'(NR)) ? sr : mix_columns(sr)) ^ rk[128*r +: 128];

  // rk, iv, st and buffer are data registers: never cleared, so iv survives a reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tx_valid    <= 1'b0;
      tx_lo       <= '0;
      tx_cmd      <= '0;
      rx_rdy      <= 1'b0;
      busy        <= 1'b0;
      block_count <= '0;
      key_idx     <= '0;
      iv_idx      <= 1'b0;
      pt_idx      <= 1'b0;
      cbc         <= 1'b1;
      r           <= '0;
    end else begin
      case (state)
        IDLE: begin
          rx_rdy <= 1'b1;
          if (rx_valid && rx_rdy) begin
            case (rx_cmd)
              8'd0: begin
                rk[64*key_idx +: 64] <= rx_lo;
                key_idx <= (key_idx == KW'(2*NR+1)) ? '0 : key_idx + KW'(1);
              end
              8'd1: begin
                if (iv_idx) iv[127:64] <= rx_lo;
                else        iv[63:0]   <= rx_lo;
                iv_idx <= ~iv_idx;
              end
              8'd2: begin
                if (!pt_idx) begin
                  buffer <= rx_lo;
                  pt_idx <= 1'b1;
                end else begin
                  st     <= {rx_lo, buffer} ^ rk[127:0] ^ (cbc ? iv : '0);
                  pt_idx <= 1'b0;
                  r      <= RW'(1);
                  state  <= ROUND;
                  rx_rdy <= 1'b0;
                  busy   <= 1'b1;
                end
              end
              8'd3: cbc <= rx_lo[0];
              8'd4: begin
                key_idx <= '0;
                iv_idx  <= 1'b0;
                pt_idx  <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        ROUND: begin
          st <= round_out;
          if (r == RW'(NR)) begin
            if (cbc) iv <= round_out;
            state    <= OUT_LO;
            tx_valid <= 1'b1;
            tx_lo    <= round_out[63:0];
            tx_cmd   <= CMD_OUT;
          end else begin
            r <= r + RW'(1);
          end
        end
        OUT_LO: begin
          if (tx_rdy) begin
            state <= OUT_HI;
            tx_lo <= st[127:64];
          end
        end
        OUT_HI: begin
          if (tx_rdy) begin
            state       <= IDLE;
            tx_valid    <= 1'b0;
            tx_lo       <= '0;
            tx_cmd      <= '0;
            block_count <= block_count + 16'd1;
            rx_rdy      <= 1'b1;
            busy        <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
